// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-stage types.
// Consumed by if_fetch_stage, its interface and ifid_reg.
package cpu_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_STEP = 2;

  localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port: req/addr out, rdata/valid back.
// The fetch stage is the master side.
interface if_fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int AW = DEF_ADDR_W,
  parameter int IW = DEF_INSTR_W
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush wins over load; the link PC is left alone on flush.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int              AW  = DEF_ADDR_W,
  parameter int              IW  = DEF_INSTR_W,
  parameter logic [IW-1:0]   NOP = DEF_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_flush,
  input  logic [IW-1:0] i_instr,
  input  logic [AW-1:0] i_pc,
  output logic          o_valid,
  output logic [IW-1:0] o_instr,
  output logic [AW-1:0] o_pc
);

  logic          r_valid;
  logic [IW-1:0] r_instr;
  logic [AW-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: FSM, skid buffer and next-PC mux feeding IF/ID.
// IF_PERF_CNT_EN adds fetch_count / stall_cycles outputs.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush_in,
  input  logic               stall_in,
  if_fetch_stage_if.master   imem,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_cycles
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t       r_state;
  fetch_state_t       w_next;
  logic [ADDR_W-1:0]  r_addr_q;
  logic [INSTR_W-1:0] r_buf;

  logic               w_req;
  logic [ADDR_W-1:0]  w_addr;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_load;
  logic               w_flush;
  logic               w_buf_ld;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [ADDR_W-1:0]  w_ld_pc;

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_addr     = r_addr_q;
    w_pc_next  = pc_in;
    w_load     = 1'b0;
    w_flush    = 1'b0;
    w_buf_ld   = 1'b0;
    w_ld_instr = imem.imem_rdata;
    if (!rst) begin
      w_pc_next = '0;
      w_next    = FETCH;
    end else begin
      unique case (r_state)
        FETCH, WAIT: begin
          w_req = 1'b1;
          if (r_state == FETCH)
            w_addr = pc_in;
          if (flush_in) begin
            w_flush   = 1'b1;
            w_pc_next = branch_target;
            // an unanswered WAIT request must be drained
            if (r_state == WAIT && !imem.imem_valid)
              w_next = DRAIN;
            else
              w_next = FETCH;
          end else if (imem.imem_valid) begin
            if (stall_in) begin
              w_buf_ld = 1'b1;
              w_next   = HOLD;
            end else begin
              w_load    = 1'b1;
              w_pc_next = pc_in + STEP;
              w_next    = FETCH;
            end
          end else begin
            w_next = WAIT;
          end
        end
        HOLD: begin
          if (flush_in) begin
            w_flush   = 1'b1;
            w_pc_next = branch_target;
            w_next    = FETCH;
          end else if (!stall_in) begin
            w_load     = 1'b1;
            w_ld_instr = r_buf;
            w_pc_next  = pc_in + STEP;
            w_next     = FETCH;
          end
        end
        DRAIN: begin
          w_req = 1'b1;
          if (flush_in) begin
            w_flush   = 1'b1;
            w_pc_next = branch_target;
          end else if (imem.imem_valid) begin
            w_next = FETCH;
          end
        end
        default: w_next = FETCH;
      endcase
    end
  end

  assign w_ld_pc = w_addr + STEP;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_addr_q <= '0;
      r_buf    <= NOP_INSTR;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH)
        r_addr_q <= pc_in;
      if (w_flush)
        r_buf <= NOP_INSTR;
      else if (w_buf_ld)
        r_buf <= imem.imem_rdata;
    end
  end

  ifid_reg #(
    .AW  (ADDR_W),
    .IW  (INSTR_W),
    .NOP (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (w_ld_instr),
    .i_pc    (w_ld_pc),
    .o_valid (ifid_valid),
    .o_instr (ifid_instr),
    .o_pc    (ifid_pc)
  );

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;
  assign pc_next        = w_pc_next;

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (stall_in && ifid_valid)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fetch_count  = r_fetch_cnt;
  assign stall_cycles = r_stall_cnt;
`endif

endmodule
